// File: rtl/bin_to_bcd8.sv
// Sequential double-dabble converter: unsigned binary to eight packed BCD digits.
// Result and overflow flag are held until the next conversion completes.
module bin_to_bcd8 #(
  parameter int unsigned IN_W = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [31:0]     bcd,
  output logic            done,
  output logic            ovf
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    LOAD
  } state_t;

  localparam logic [4:0] LAST = 5'(IN_W - 1);

  state_t          state_q;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [31:0]     acc_q, acc_d, acc_adj;
  logic [4:0]      cnt_q, cnt_d;
  logic            ov_pend_q;
  logic            ov_in;
  logic [31:0]     bcd_q;
  logic            done_q;
  logic            ovf_q;
  logic [3:0]      nib;

  // Inputs narrower than 27 bits can never exceed 99_999_999, so this folds to 0.
  always_comb begin
    ov_in = 1'b0;
    if (IN_W >= 27) ov_in = (32'(in_data) > 32'd99_999_999);
  end

  always_comb begin
    acc_adj = '0;
    nib     = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      nib = acc_q[4*k +: 4];
      acc_adj[4*k +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  end

  always_comb begin
    acc_d = {acc_adj[30:0], bin_q[IN_W-1]};
    bin_d = bin_q << 1;
    cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ov_pend_q <= 1'b0;
      bcd_q     <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            bin_q     <= in_data;
            acc_q     <= '0;
            cnt_q     <= '0;
            ov_pend_q <= ov_in;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          bin_q <= bin_d;
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_q == LAST) state_q <= LOAD;
        end
        LOAD: begin
          bcd_q   <= ov_pend_q ? 32'h9999_9999 : acc_q;
          ovf_q   <= ov_pend_q;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_q == IDLE);
  assign bcd      = bcd_q;
  assign done     = done_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd8.sv
// Scoreboard bench for bin_to_bcd8: stimulus queues expected results, monitors
// pop and compare on each done pulse, including the exact completion cycle.
module tb_bin_to_bcd8;

  localparam int unsigned W  = 27;
  localparam int unsigned W8 = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [26:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] bcd;
  logic        done;
  logic        ovf;

  logic [7:0]  in_data8;
  logic        in_valid8;
  logic        in_ready8;
  logic [31:0] bcd8;
  logic        done8;
  logic        ovf8;

  always #5 clk = ~clk;

  bin_to_bcd8 #(.IN_W(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .bcd(bcd), .done(done), .ovf(ovf)
  );

  bin_to_bcd8 #(.IN_W(W8)) dut8 (
    .clk(clk), .rst(rst), .in_data(in_data8), .in_valid(in_valid8),
    .in_ready(in_ready8), .bcd(bcd8), .done(done8), .ovf(ovf8)
  );

  typedef struct {
    logic [31:0] bcd;
    logic        ovf;
    int unsigned when;
  } exp_t;

  exp_t q27[$];
  exp_t q8[$];

  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int unsigned last_acc = 0;
  logic        prev_done = 1'b0;
  logic        prev_done8 = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    int unsigned x;
    r = '0;
    x = v;
    if (x > 99_999_999) return 32'h9999_9999;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitors: one pop per done pulse.
  always @(negedge clk) begin
    if (!rst && done) begin
      chk("done27_single_pulse", 32'(prev_done), 32'd0);
      if (q27.size() == 0) fail_now("done27_unexpected");
      else begin
        exp_t e;
        e = q27.pop_front();
        chk("bcd27", bcd, e.bcd);
        chk("ovf27", 32'(ovf), 32'(e.ovf));
        chk("latency27", cyc, e.when);
      end
    end
    prev_done = done;
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      chk("done8_single_pulse", 32'(prev_done8), 32'd0);
      if (q8.size() == 0) fail_now("done8_unexpected");
      else begin
        exp_t e;
        e = q8.pop_front();
        chk("bcd8", bcd8, e.bcd);
        chk("ovf8", 32'(ovf8), 32'(e.ovf));
        chk("latency8", cyc, e.when);
      end
    end
    prev_done8 = done8;
  end

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send27(input int unsigned v, input logic [31:0] eb, input logic eo,
                        input bit push, input bit hold);
    int unsigned n;
    n = 0;
    in_data  = 27'(v);
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail_now("accept27_timeout");
      in_valid = 1'b0;
      return;
    end
    last_acc = cyc;
    if (push) q27.push_back('{eb, eo, cyc + W + 2});
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic send8(input int unsigned v, input logic [31:0] eb);
    int unsigned n;
    n = 0;
    in_data8  = 8'(v);
    in_valid8 = 1'b1;
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      fail_now("accept8_timeout");
      in_valid8 = 1'b0;
      return;
    end
    q8.push_back('{eb, 1'b0, cyc + W8 + 2});
    @(negedge clk);
    in_valid8 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a1;
    int unsigned v;
    logic [31:0] held;

    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_data8 = '0; in_valid8 = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_bcd", bcd, 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion with busy-window checks on in_ready and held bcd.
    held = bcd;
    send27(12_345_678, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(W) + 1; i++) begin
      chk("busy_in_ready_low", 32'(in_ready), 32'd0);
      chk("busy_bcd_held", bcd, held);
      @(negedge clk);
    end
    chk("idle_in_ready_high", 32'(in_ready), 32'd1);

    send27(0,           32'h0000_0000, 1'b0, 1'b1, 1'b0);
    send27(99_999_999,  32'h9999_9999, 1'b0, 1'b1, 1'b0);
    send27(10,          32'h0000_0010, 1'b0, 1'b1, 1'b0);
    send27(100_000_000, 32'h9999_9999, 1'b1, 1'b1, 1'b0);
    send27(7,           32'h0000_0007, 1'b0, 1'b1, 1'b0);
    send27(99_999_998,  32'h9999_9998, 1'b0, 1'b1, 1'b0);
    send27(134_217_727, 32'h9999_9999, 1'b1, 1'b1, 1'b0);
    send27(100_000_001, 32'h9999_9999, 1'b1, 1'b1, 1'b0);
    send27(10_000_000,  32'h1000_0000, 1'b0, 1'b1, 1'b0);

    // Back-to-back with in_valid held; in_data changes during BUSY.
    send27(5, 32'h0000_0005, 1'b0, 1'b1, 1'b1);
    a1 = last_acc;
    in_data = 27'd42;
    send27(42, 32'h0000_0042, 1'b0, 1'b1, 1'b0);
    chk("back_to_back_spacing", last_acc - a1, W + 2);

    // Reset mid-conversion aborts without a done pulse.
    send27(87_654_321, 32'h0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_bcd_zero", bcd, 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_done_low", 32'(done), 32'd0);
    chk("abort_ovf_low", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_bcd_stays_zero", bcd, 32'd0);
    end
    send27(87_654_321, 32'h8765_4321, 1'b0, 1'b1, 1'b0);

    // Random values against the decimal reference model.
    for (int i = 0; i < 200; i++) begin
      v = $urandom_range(134_217_727, 0);
      send27(v, ref_bcd(v), (v > 99_999_999), 1'b1, 1'b0);
    end

    // Narrow instance.
    send8(255, 32'h0000_0255);
    send8(0,   32'h0000_0000);
    send8(99,  32'h0000_0099);
    send8(128, 32'h0000_0128);

    for (int n = 0; n < 200 && (q27.size() != 0 || q8.size() != 0); n++) @(negedge clk);
    chk("q27_drained", 32'(q27.size()), 32'd0);
    chk("q8_drained", 32'(q8.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
